// File: rtl/module_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: drives stage stall/flush
// controls for load-use, mispredict and data-memory waits, with perf counters.
module module_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] rs1_d_i,
  input  logic [REG_W-1:0] rs2_d_i,
  input  logic [REG_W-1:0] rd_e_i,
  input  logic             load_e_i,
  input  logic             mispredict_e_i,
  input  logic             mem_req_m_i,
  input  logic             mem_ready_i,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             stall_e_o,
  output logic             stall_m_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             flush_w_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  // The RUN cycle is wait cycle 1, so MEM_WAIT gives up after MEM_TIMEOUT-1 of its own.
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TRAP     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic memwait_s;
  logic lu_s;
  logic stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic flush_d_s, flush_e_s, flush_w_s;

  assign memwait_s = mem_req_m_i & ~mem_ready_i;
  assign lu_s      = load_e_i & (rd_e_i != '0) &
                     ((rd_e_i == rs1_d_i) | (rd_e_i == rs2_d_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (memwait_s) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (!memwait_s) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_LAST) begin
          state_d   = ST_TRAP;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      ST_TRAP: begin
        state_d   = ST_TRAP;
        mem_err_d = 1'b1;
      end
      default: begin
        // An illegal encoding is treated as a fault and parks the pipeline.
        state_d   = ST_TRAP;
        mem_err_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    flush_w_s = 1'b0;
    if (rst_i) begin
      flush_w_s = 1'b0;
    end else begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (memwait_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
          end else if (mispredict_e_i) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
          end else if (lu_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
          end else begin
            flush_w_s = 1'b0;
          end
        end
        default: begin
          stall_f_s = 1'b1;
          stall_d_s = 1'b1;
          stall_e_s = 1'b1;
          stall_m_s = 1'b1;
          flush_w_s = 1'b1;
        end
      endcase
    end
  end

  // flush_d only ever asserts for an unmasked mispredict, so it marks a flush event.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_d_s && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  assign stall_f_o   = stall_f_s;
  assign stall_d_o   = stall_d_s;
  assign stall_e_o   = stall_e_s;
  assign stall_m_o   = stall_m_s;
  assign flush_d_o   = flush_d_s;
  assign flush_e_o   = flush_e_s;
  assign flush_w_o   = flush_w_s;
  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_module_hazard_ctrl.sv
// Self-checking bench for module_hazard_ctrl: directed scenarios plus randomized
// traffic against a cycle-level reference model of the hazard rules.
module tb_module_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int MT    = 4;
  localparam int CW    = 8;
  localparam int CMAX  = 255;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [REG_W-1:0] rs1_d_i, rs2_d_i, rd_e_i;
  logic             load_e_i, mispredict_e_i, mem_req_m_i, mem_ready_i;
  logic             stall_f_o, stall_d_o, stall_e_o, stall_m_o;
  logic             flush_d_o, flush_e_o, flush_w_o, mem_err_o;
  logic [CW-1:0]    stall_cnt_o, flush_cnt_o;
  logic [6:0]       outs;

  module_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i), .rd_e_i(rd_e_i),
    .load_e_i(load_e_i), .mispredict_e_i(mispredict_e_i),
    .mem_req_m_i(mem_req_m_i), .mem_ready_i(mem_ready_i),
    .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .stall_e_o(stall_e_o),
    .stall_m_o(stall_m_o), .flush_d_o(flush_d_o), .flush_e_o(flush_e_o),
    .flush_w_o(flush_w_o), .mem_err_o(mem_err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  assign outs = {stall_f_o, stall_d_o, stall_e_o, stall_m_o, flush_d_o, flush_e_o, flush_w_o};

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: trapped flag, length of the current memory-wait run, counters.
  bit m_trap;
  int m_run;
  bit m_err;
  int m_scnt;
  int m_fcnt;

  function automatic logic [6:0] exp_outs();
    bit mw, lu;
    mw = mem_req_m_i && !mem_ready_i;
    lu = load_e_i && (rd_e_i != 0) && (rd_e_i == rs1_d_i || rd_e_i == rs2_d_i);
    if (rst_i)          return 7'b0000000;
    if (m_trap || mw)   return 7'b1111001;
    if (mispredict_e_i) return 7'b0000110;
    if (lu)             return 7'b1100010;
    return 7'b0000000;
  endfunction

  task automatic model_reset();
    m_trap = 1'b0; m_run = 0; m_err = 1'b0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic tick();
    logic [6:0] e;
    bit mw;
    @(posedge clk_i);
    e  = exp_outs();
    mw = mem_req_m_i && !mem_ready_i;
    if (e[6] && m_scnt < CMAX) m_scnt++;
    if (!m_trap && !mw && mispredict_e_i && m_fcnt < CMAX) m_fcnt++;
    if (!m_trap) begin
      if (mw) begin
        m_run++;
        if (m_run == MT) begin m_trap = 1'b1; m_err = 1'b1; end
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic drive(input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic mis, input logic req, input logic rdy);
    load_e_i = ld; rd_e_i = rd; rs1_d_i = r1; rs2_d_i = r2;
    mispredict_e_i = mis; mem_req_m_i = req; mem_ready_i = rdy;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b1, 5'd7, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0);
    model_reset();
    #3;
    n_cmp++;
    if (outs !== 7'b0000000) begin n_fail++; $display("FAIL reset_outs: got %b want 0000000", outs); end
    n_cmp++;
    if (mem_err_o !== 1'b0 || stall_cnt_o !== 8'd0 || flush_cnt_o !== 8'd0) begin
      n_fail++; $display("FAIL reset_regs: err=%b scnt=%0d fcnt=%0d want 0/0/0", mem_err_o, stall_cnt_o, flush_cnt_o);
    end
    @(posedge clk_i); #1 rst_i = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    n_cmp++;
    if (outs !== exp_outs() || outs !== 7'b1100010) begin n_fail++; $display("FAIL lu_bubble: got %b want 1100010", outs); end
    tick();
    drive(1'b0, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    n_cmp++;
    if (outs !== 7'b0000000 || stall_cnt_o !== CW'(m_scnt) || stall_cnt_o !== 8'd1) begin
      n_fail++; $display("FAIL lu_after: outs=%b scnt=%0d want 0000000/1", outs, stall_cnt_o);
    end
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    n_cmp++;
    if (outs !== 7'b0000000) begin n_fail++; $display("FAIL lu_x0: got %b want 0000000", outs); end
    tick();
  endtask

  task automatic test_mispredict_lu();
    do_reset();
    drive(1'b1, 5'd9, 5'd9, 5'd2, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    n_cmp++;
    if (outs !== 7'b0000110) begin n_fail++; $display("FAIL mis_over_lu: got %b want 0000110", outs); end
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    n_cmp++;
    if (flush_cnt_o !== 8'd1 || stall_cnt_o !== 8'd0) begin
      n_fail++; $display("FAIL mis_cnt: fcnt=%0d scnt=%0d want 1/0", flush_cnt_o, stall_cnt_o);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, (i == 3));
      @(negedge clk_i);
      n_cmp++;
      if (outs !== exp_outs()) begin n_fail++; $display("FAIL memwait_c%0d: got %b want %b", i, outs, exp_outs()); end
      tick();
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    n_cmp++;
    if (stall_cnt_o !== 8'd3 || mem_err_o !== 1'b0) begin
      n_fail++; $display("FAIL memwait_cnt: scnt=%0d err=%b want 3/0", stall_cnt_o, mem_err_o);
    end
    tick();
  endtask

  task automatic test_mispredict_in_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, (i < 3), 1'b1, (i >= 2));
      @(negedge clk_i);
      n_cmp++;
      if (outs !== exp_outs()) begin n_fail++; $display("FAIL mis_wait_c%0d: got %b want %b", i, outs, exp_outs()); end
      tick();
    end
    @(negedge clk_i);
    n_cmp++;
    if (flush_cnt_o !== 8'd1 || stall_cnt_o !== 8'd2) begin
      n_fail++; $display("FAIL mis_wait_cnt: fcnt=%0d scnt=%0d want 1/2", flush_cnt_o, stall_cnt_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 5'd4, 5'd4, 5'd0, (i == 7), 1'b1, (i >= 6));
      @(negedge clk_i);
      n_cmp++;
      if (outs !== exp_outs() || mem_err_o !== m_err) begin
        n_fail++; $display("FAIL timeout_c%0d: outs=%b err=%b want %b/%b", i, outs, mem_err_o, exp_outs(), m_err);
      end
      tick();
    end
    n_cmp++;
    if (mem_err_o !== 1'b1 || outs !== 7'b1111001) begin
      n_fail++; $display("FAIL timeout_trap: err=%b outs=%b want 1/1111001", mem_err_o, outs);
    end
  endtask

  task automatic test_reset_from_trap();
    @(negedge clk_i); #2;
    drive(1'b1, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (outs !== 7'b0000000 || mem_err_o !== 1'b0 || stall_cnt_o !== 8'd0 || flush_cnt_o !== 8'd0) begin
      n_fail++; $display("FAIL async_rst: outs=%b err=%b scnt=%0d fcnt=%0d want all 0", outs, mem_err_o, stall_cnt_o, flush_cnt_o);
    end
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (outs !== 7'b1100010) begin n_fail++; $display("FAIL post_rst_lu: got %b want 1100010", outs); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    @(negedge clk_i);
    n_cmp++;
    if (stall_cnt_o !== 8'hFF || flush_cnt_o !== 8'hFF) begin
      n_fail++; $display("FAIL saturate: scnt=%0d fcnt=%0d want 255/255", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m_trap && ($urandom_range(0, 5) == 0)) begin
        do_reset();
      end
      drive(1'(($urandom_range(0, 1))), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0),
            ((i % 300) > 240) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0));
      @(negedge clk_i);
      n_cmp++;
      if (outs !== exp_outs()) begin n_fail++; $display("FAIL rand_outs c%0d: got %b want %b", i, outs, exp_outs()); end
      n_cmp++;
      if (mem_err_o !== m_err || stall_cnt_o !== CW'(m_scnt) || flush_cnt_o !== CW'(m_fcnt)) begin
        n_fail++; $display("FAIL rand_regs c%0d: err=%b scnt=%0d fcnt=%0d want %b/%0d/%0d",
                           i, mem_err_o, stall_cnt_o, flush_cnt_o, m_err, m_scnt, m_fcnt);
      end
      tick();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    test_reset();
    test_load_use();
    test_mispredict_lu();
    test_mem_wait();
    test_mispredict_in_wait();
    test_timeout();
    test_reset_from_trap();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
